cbus_mem_responder: RTL

Cache-bus (cbus) responder: a synchronous on-chip 64-bit memory that serves the cbus requests issued by the data/instruction caches and their uncached paths. It accepts one request at a time, latches the burst descriptor, then returns one beat per `cresp.ready` pulse with `cresp.last` on the final beat. It sits at the memory side of the cbus, replacing the external AXI bridge in cache-level simulation and FPGA bring-up.

---
 rtl/cbus_mem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: single-outstanding burst slave backed by an on-chip 64-bit RAM.
// Define CBUS_RESP_WAIT_EN to add a first-beat WAIT latency and a stall cycle after every beat.
package cbus_pkg;
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    localparam int AW = $clog2(MEM_WORDS);

`ifdef CBUS_RESP_WAIT_EN
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;
    logic [WW-1:0] wait_cnt;
`else
    typedef enum logic [1:0] {IDLE, BEAT} state_t;
`endif

    state_t        state;
    logic [AW-1:0] index_q;
    logic          is_write_q;
    axi_burst_t    burst_q;
    logic [3:0]    len_q;
    logic [3:0]    beat_cnt;
    logic          ready_q;
    logic          last_q;

    logic [63:0]   mem [MEM_WORDS];
    logic          beat_fire;
    logic [AW-1:0] next_index;
    logic          unused_req_bits;

    // A dropped valid gates ready in the same cycle, so an aborted burst never shows a phantom beat.
    assign beat_fire  = ready_q && creq.valid;
    assign next_index = (burst_q == AXI_BURST_FIXED) ? index_q : index_q + 1'b1;
    assign unused_req_bits = ^{creq.size, creq.addr[2:0], creq.addr[31:AW+3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            index_q    <= '0;
            is_write_q <= 1'b0;
            burst_q    <= AXI_BURST_FIXED;
            len_q      <= '0;
            beat_cnt   <= '0;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef CBUS_RESP_WAIT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (creq.valid) begin
                        index_q    <= creq.addr[AW+2:3];
                        is_write_q <= creq.is_write;
                        burst_q    <= creq.burst;
                        len_q      <= creq.len;
                        beat_cnt   <= '0;
`ifdef CBUS_RESP_WAIT_EN
                        wait_cnt   <= '0;
                        if (LATENCY == 0) begin
                            state   <= BEAT;
                            ready_q <= 1'b1;
                            last_q  <= (creq.len == 4'd0);
                        end else begin
                            state   <= WAIT;
                        end
`else
                        state      <= BEAT;
                        ready_q    <= 1'b1;
                        last_q     <= (creq.len == 4'd0);
`endif
                    end
                end
`ifdef CBUS_RESP_WAIT_EN
                WAIT: begin
                    if (!creq.valid) begin
                        state <= IDLE;
                    end else if (wait_cnt == WW'(LATENCY - 1)) begin
                        state   <= BEAT;
                        ready_q <= 1'b1;
                        last_q  <= (len_q == 4'd0);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
`endif
                BEAT: begin
                    if (!creq.valid) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (ready_q) begin
                        index_q <= next_index;
                        if (beat_cnt == len_q) begin
                            state   <= IDLE;
                            ready_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
`ifdef CBUS_RESP_WAIT_EN
                            ready_q  <= 1'b0;
                            last_q   <= 1'b0;
`else
                            last_q   <= ((beat_cnt + 4'd1) == len_q);
`endif
                        end
                    end
`ifdef CBUS_RESP_WAIT_EN
                    else begin
                        ready_q <= 1'b1;
                        last_q  <= (beat_cnt == len_q);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset on purpose; a reset would stop it mapping onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (beat_fire && is_write_q) begin
            for (int i = 0; i < 8; i++) begin
                if (creq.strobe[i]) begin
                    mem[index_q][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: default the whole struct first so no path through this block can infer a latch.
    always_comb begin
        cresp       = '0;
        cresp.ready = beat_fire;
        cresp.last  = beat_fire && last_q;
        if (beat_fire && !is_write_q) begin
            cresp.data = mem[index_q];
        end
    end
endmodule
